// File: rtl/pe_edge_feeder.sv
// pe_edge_feeder
//   Feeds one boundary lane (row or column) of the systolic PE array.
//   Operands are buffered in a show-ahead FIFO. A start command, after SKEW
//   idle cycles that form the diagonal wavefront, streams exactly K operands
//   into the edge PE over a valid/ready port and then pulses done for one
//   cycle. Operands beyond K remain queued for the next pass.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   start      begin one K-operand pass (honoured only when idle)
//   in_valid   upstream operand valid
//   in_ready   FIFO not full
//   in_dat     upstream operand
//   out_valid  operand valid toward the PE
//   out_ready  PE ready
//   out_dat    operand toward the PE (zero whenever out_valid is low)
//   busy       pass in progress (skew, stream and the done cycle)
//   done       one-cycle pulse after the K-th transfer
//   level      current FIFO occupancy
module pe_edge_feeder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int K      = 4,
  parameter int SKEW   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_dat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_dat,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(K + 1);
  // A zero-skew lane still needs a one-bit counter to keep the vector legal.
  localparam int SW = (SKEW > 0) ? $clog2(SKEW + 1) : 1;

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [IW-1:0] ISSUE_LAST = IW'(K - 1);
  localparam logic [SW-1:0] SKEW_LAST  = (SKEW > 0) ? SW'(SKEW - 1) : SW'(0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SKEW   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [LW-1:0]       level_r;
  logic [IW-1:0]       issue_cnt_r;
  logic [SW-1:0]       skew_cnt_r;

  logic                push_s;
  logic                pop_s;
  logic                out_valid_s;

  // Handshake decode; out_valid depends only on registered state, never on out_ready.
  always_comb begin
    out_valid_s = (state_r == ST_STREAM) && (level_r != {LW{1'b0}});
    push_s      = in_valid && (level_r != FULL_LEVEL);
    pop_s       = out_valid_s && out_ready;
  end

  assign in_ready  = (level_r != FULL_LEVEL);
  assign out_valid = out_valid_s;
  // Head entry is shown directly from memory, masked to zero when not offered.
  assign out_dat   = out_valid_s ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
  // busy covers the done cycle so a lane reads busy until its pass has completed.
  assign busy      = (state_r != ST_IDLE);
  assign done      = (state_r == ST_DONE);
  assign level     = level_r;

  // FIFO storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_dat;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; start is only looked at in IDLE and is never queued.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = (SKEW > 0) ? ST_SKEW : ST_STREAM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SKEW: begin
        if (skew_cnt_r == SKEW_LAST) begin
          state_s = ST_STREAM;
        end else begin
          state_s = ST_SKEW;
        end
      end
      ST_STREAM: begin
        if (pop_s && (issue_cnt_r == ISSUE_LAST)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Skew and issue counters; both are cleared while idle so each pass starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      skew_cnt_r  <= {SW{1'b0}};
      issue_cnt_r <= {IW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          skew_cnt_r  <= {SW{1'b0}};
          issue_cnt_r <= {IW{1'b0}};
        end
        ST_SKEW: begin
          skew_cnt_r <= skew_cnt_r + SW'(1);
        end
        ST_STREAM: begin
          if (pop_s) begin
            issue_cnt_r <= issue_cnt_r + IW'(1);
          end
        end
        ST_DONE: begin
          skew_cnt_r  <= skew_cnt_r;
          issue_cnt_r <= issue_cnt_r;
        end
        default: begin
          skew_cnt_r  <= {SW{1'b0}};
          issue_cnt_r <= {IW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_edge_feeder.sv
// Directed self-checking bench for pe_edge_feeder.
// Instance a: K=4, SKEW=0, DEPTH=8. Instance b: K=4, SKEW=3, DEPTH=8.
module tb_pe_edge_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy, a_done;
  logic [31:0] a_in_dat, a_out_dat;
  logic [3:0]  a_level;

  logic        b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_done;
  logic [31:0] b_in_dat, b_out_dat;
  logic [3:0]  b_level;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_a [4];
  logic [31:0] vals  [4];

  pe_edge_feeder #(.DATA_W(32), .DEPTH(8), .K(4), .SKEW(0)) dut_a (
    .clk(clk), .rst(rst), .start(a_start),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_dat(a_in_dat),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_dat(a_out_dat),
    .busy(a_busy), .done(a_done), .level(a_level)
  );

  pe_edge_feeder #(.DATA_W(32), .DEPTH(8), .K(4), .SKEW(3)) dut_b (
    .clk(clk), .rst(rst), .start(b_start),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_dat(b_in_dat),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_dat(b_out_dat),
    .busy(b_busy), .done(b_done), .level(b_level)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    a_start = 1'b0; a_in_valid = 1'b0; a_in_dat = 32'h0; a_out_ready = 1'b0;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_dat = 32'h0; b_out_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic push_a(input logic [31:0] v);
    a_in_valid = 1'b1;
    a_in_dat   = v;
    tick;
    a_in_valid = 1'b0;
    a_in_dat   = 32'h0;
  endtask

  // One full pass on instance a with out_ready held high, expecting exp_a in order.
  task automatic run_pass_a(input string tag);
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_valid"}, 32'(a_out_valid), 32'd1);
      check({tag, "_dat"}, a_out_dat, exp_a[i]);
      check({tag, "_nodone"}, 32'(a_done), 32'd0);
      tick;
    end
    check({tag, "_done"}, 32'(a_done), 32'd1);
    check({tag, "_done_novalid"}, 32'(a_out_valid), 32'd0);
    a_out_ready = 1'b0;
    tick;
    check({tag, "_done_once"}, 32'(a_done), 32'd0);
    check({tag, "_idle"}, 32'(a_busy), 32'd0);
  endtask

  initial begin
    int idx;
    int c;
    int ml;
    int pushed;
    int popped;
    logic do_push;
    logic do_pop;

    // ---------------- reset state ----------------
    do_reset;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_dat", a_out_dat, 32'h0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_level", 32'(a_level), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd1);

    // ---------------- 1: basic pass, SKEW=0 ----------------
    exp_a[0] = 32'h3F800000; exp_a[1] = 32'h40000000;
    exp_a[2] = 32'h40400000; exp_a[3] = 32'h40800000;
    for (int i = 0; i < 4; i++) push_a(exp_a[i]);
    check("t1_level4", 32'(a_level), 32'd4);
    check("t1_prefill_novalid", 32'(a_out_valid), 32'd0);
    run_pass_a("t1");
    check("t1_level0", 32'(a_level), 32'd0);

    // ---------------- 2: SKEW=3 wavefront timing ----------------
    vals[0] = 32'h3F000000; vals[1] = 32'h3E800000;
    vals[2] = 32'h3E000000; vals[3] = 32'h3D800000;
    b_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_in_dat = vals[i];
      tick;
    end
    b_in_valid = 1'b0;
    b_in_dat = 32'h0;
    check("t2_level4", 32'(b_level), 32'd4);
    check("t2_busy_t", 32'(b_busy), 32'd0);
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    b_out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("t2_busy_t+%0d", k), 32'(b_busy), 32'd1);
      check($sformatf("t2_valid_t+%0d", k), 32'(b_out_valid), (k >= 4 && k <= 7) ? 32'd1 : 32'd0);
      check($sformatf("t2_done_t+%0d", k), 32'(b_done), (k == 8) ? 32'd1 : 32'd0);
      if (k >= 4 && k <= 7) check($sformatf("t2_dat_t+%0d", k), b_out_dat, vals[k-4]);
      tick;
    end
    b_out_ready = 1'b0;
    check("t2_busy_t+9", 32'(b_busy), 32'd0);
    check("t2_level0", 32'(b_level), 32'd0);

    // ---------------- 3: backpressure, start ignored mid-pass ----------------
    exp_a[0] = 32'h40A00000; exp_a[1] = 32'h40C00000;
    exp_a[2] = 32'h40E00000; exp_a[3] = 32'h41000000;
    for (int i = 0; i < 4; i++) push_a(exp_a[i]);
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    idx = 0;
    c = 0;
    while (idx < 4 && c < 30) begin
      a_out_ready = (c % 3 == 0);
      a_start = (idx == 1);
      check($sformatf("t3_valid_c%0d", c), 32'(a_out_valid), 32'd1);
      check($sformatf("t3_dat_c%0d", c), a_out_dat, exp_a[idx]);
      tick;
      if (a_out_ready) idx++;
      c++;
    end
    a_start = 1'b0;
    a_out_ready = 1'b0;
    check("t3_beats", 32'(idx), 32'd4);
    check("t3_done", 32'(a_done), 32'd1);
    tick;
    check("t3_no_requeue", 32'(a_busy), 32'd0);
    check("t3_level0", 32'(a_level), 32'd0);

    // ---------------- 4: full FIFO, simultaneous push/pop, wrap ----------------
    for (int i = 0; i < 8; i++) push_a(32'h100 + 32'(i));
    check("t4_level8", 32'(a_level), 32'd8);
    check("t4_full_not_ready", 32'(a_in_ready), 32'd0);
    push_a(32'hDEAD);
    check("t4_9th_ignored", 32'(a_level), 32'd8);
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    a_out_ready = 1'b1;
    check("t4_dat0", a_out_dat, 32'h100);
    tick;
    check("t4_level7a", 32'(a_level), 32'd7);
    a_in_valid = 1'b1; a_in_dat = 32'h108;
    check("t4_dat1", a_out_dat, 32'h101);
    tick;
    check("t4_level7b", 32'(a_level), 32'd7);
    a_in_dat = 32'h109;
    check("t4_dat2", a_out_dat, 32'h102);
    tick;
    check("t4_level7c", 32'(a_level), 32'd7);
    a_in_valid = 1'b0; a_in_dat = 32'h0;
    check("t4_dat3", a_out_dat, 32'h103);
    tick;
    check("t4_done", 32'(a_done), 32'd1);
    check("t4_level6", 32'(a_level), 32'd6);
    a_out_ready = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) exp_a[i] = 32'h104 + 32'(i);
    run_pass_a("t4p2");
    check("t4_level2", 32'(a_level), 32'd2);
    push_a(32'h10A);
    push_a(32'h10B);
    for (int i = 0; i < 4; i++) exp_a[i] = 32'h108 + 32'(i);
    run_pass_a("t4wrap");
    check("t4_level0", 32'(a_level), 32'd0);

    // ---------------- 5: start with empty FIFO, trickle feed ----------------
    do_reset;
    vals[0] = 32'h41100000; vals[1] = 32'h41200000;
    vals[2] = 32'h41300000; vals[3] = 32'h41400000;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    a_out_ready = 1'b1;
    ml = 0; pushed = 0; popped = 0; c = 0;
    while (popped < 4 && c < 40) begin
      check($sformatf("t5_valid_c%0d", c), 32'(a_out_valid), (ml != 0) ? 32'd1 : 32'd0);
      if (ml != 0) check($sformatf("t5_dat_c%0d", c), a_out_dat, vals[popped]);
      check($sformatf("t5_nodone_c%0d", c), 32'(a_done), 32'd0);
      do_push = (c % 3 == 0) && (pushed < 4);
      do_pop  = (ml != 0);
      a_in_valid = do_push;
      a_in_dat   = do_push ? vals[pushed] : 32'h0;
      tick;
      if (do_push) begin pushed++; ml++; end
      if (do_pop)  begin popped++; ml--; end
      c++;
    end
    a_in_valid = 1'b0;
    a_in_dat = 32'h0;
    check("t5_beats", 32'(popped), 32'd4);
    check("t5_done", 32'(a_done), 32'd1);
    a_out_ready = 1'b0;
    tick;
    check("t5_idle", 32'(a_busy), 32'd0);

    // ---------------- 6: reset mid-pass ----------------
    do_reset;
    for (int i = 0; i < 4; i++) push_a(32'h200 + 32'(i));
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    a_out_ready = 1'b1;
    check("t6_dat0", a_out_dat, 32'h200);
    tick;
    check("t6_dat1", a_out_dat, 32'h201);
    tick;
    a_out_ready = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t6_valid0", 32'(a_out_valid), 32'd0);
    check("t6_dat_zero", a_out_dat, 32'h0);
    check("t6_level0", 32'(a_level), 32'd0);
    check("t6_idle", 32'(a_busy), 32'd0);
    check("t6_in_ready", 32'(a_in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_nodone_%0d", i), 32'(a_done), 32'd0);
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
